// File: rtl/rv32_mmio_timer_pkg.sv
// Shared definitions for the MMIO machine timer bridge.
// Holds the register offsets inside the 32-byte window and the CTRL field layout.
package rv32_mmio_timer_pkg;

    localparam int TMR_PRESC_W = 8;

    localparam logic [4:0] TMR_MTIME_LO = 5'h00;
    localparam logic [4:0] TMR_MTIME_HI = 5'h04;
    localparam logic [4:0] TMR_CMP_LO   = 5'h08;
    localparam logic [4:0] TMR_CMP_HI   = 5'h0C;
    localparam logic [4:0] TMR_CTRL     = 5'h10;
    localparam logic [4:0] TMR_STATUS   = 5'h14;
    localparam logic [4:0] TMR_MSIP     = 5'h18;

    typedef struct packed {
        logic [TMR_PRESC_W-1:0] presc;
        logic [5:0]             rsvd;
        logic                   irq_en;
        logic                   en;
    } tmr_ctrl_t;

endpackage

// File: rtl/rv32_mmio_timer_if.sv
// Data-memory bus between core MEM stage, the timer bridge and data RAM.
// master: core/RAM side (drives dmem_*, ram_rdata); slave: the bridge.
interface rv32_mmio_timer_if;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    modport master (
        output dmem_addr, dmem_wdata, dmem_we, ram_rdata,
        input  dmem_rdata, ram_addr, ram_wdata, ram_we
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_we, ram_rdata,
        output dmem_rdata, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/rv32_timer_prescaler.sv
// Prescaler for the machine timer: ticks once every presc+1 cycles while en.
// Ports: clk, rst (sync, active-high), en, presc, clr (restart count) -> tick.
module rv32_timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en & (pcnt == presc);

    always_ff @(posedge clk) begin
        if (rst || clr || !en)
            pcnt <= '0;
        else if (pcnt == presc)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

endmodule

// File: rtl/rv32_mmio_timer.sv
// Dmem bridge with a 64-bit mtime/mtimecmp timer in a 32-byte MMIO window.
// Ports: clk, rst (sync, active-high), bus (slave), irq_o. Option: RV32_TIMER_MSIP_EN.
module rv32_mmio_timer
    import rv32_mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int          PRESC_W   = TMR_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    rv32_mmio_timer_if.slave   bus,
    output logic               irq_o
);

    logic               sel;
    logic [4:0]         off;
    logic [31:0]        reg_rd;
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic               en;
    logic               irq_en;
    logic [PRESC_W-1:0] presc;
    logic               ovf;
    logic               match;
    logic               tick;
    logic               wr;
    logic               wr_mlo, wr_mhi, wr_clo, wr_chi;
    logic               wr_ctrl, wr_stat;
    logic               msip;

    assign sel = (bus.dmem_addr[31:5] == BASE_ADDR[31:5]);
    assign off = bus.dmem_addr[4:0];
    assign wr  = bus.dmem_we & sel;

    assign wr_mlo  = wr & (off == TMR_MTIME_LO);
    assign wr_mhi  = wr & (off == TMR_MTIME_HI);
    assign wr_clo  = wr & (off == TMR_CMP_LO);
    assign wr_chi  = wr & (off == TMR_CMP_HI);
    assign wr_ctrl = wr & (off == TMR_CTRL);
    assign wr_stat = wr & (off == TMR_STATUS);

    assign bus.ram_addr   = bus.dmem_addr;
    assign bus.ram_wdata  = bus.dmem_wdata;
    assign bus.ram_we     = bus.dmem_we & ~sel;
    assign bus.dmem_rdata = sel ? reg_rd : bus.ram_rdata;

    assign match = (mtime >= mtimecmp);

    rv32_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .presc (presc),
        .clr   (wr_ctrl),
        .tick  (tick)
    );

    // A software write to either half owns the cycle; the tick is dropped.
    always_ff @(posedge clk) begin
        if (rst)
            mtime <= '0;
        else if (wr_mlo)
            mtime[31:0] <= bus.dmem_wdata;
        else if (wr_mhi)
            mtime[63:32] <= bus.dmem_wdata;
        else if (tick)
            mtime <= mtime + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            mtimecmp <= '1;
        else if (wr_clo)
            mtimecmp[31:0] <= bus.dmem_wdata;
        else if (wr_chi)
            mtimecmp[63:32] <= bus.dmem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en     <= 1'b0;
            irq_en <= 1'b0;
            presc  <= '0;
        end else if (wr_ctrl) begin
            en     <= bus.dmem_wdata[0];
            irq_en <= bus.dmem_wdata[1];
            presc  <= bus.dmem_wdata[8 +: PRESC_W];
        end
    end

    // Wrap sets ovf and beats a simultaneous W1C.
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (tick && !wr_mlo && !wr_mhi && (mtime == '1))
            ovf <= 1'b1;
        else if (wr_stat && bus.dmem_wdata[1])
            ovf <= 1'b0;
    end

`ifdef RV32_TIMER_MSIP_EN
    logic wr_msip;
    assign wr_msip = wr & (off == TMR_MSIP);

    always_ff @(posedge clk) begin
        if (rst)
            msip <= 1'b0;
        else if (wr_msip)
            msip <= bus.dmem_wdata[0];
    end
`else
    assign msip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            irq_o <= 1'b0;
        else
            irq_o <= (irq_en & match) | msip;
    end

    always_comb begin
        reg_rd = '0;
        case (off)
            TMR_MTIME_LO: reg_rd = mtime[31:0];
            TMR_MTIME_HI: reg_rd = mtime[63:32];
            TMR_CMP_LO:   reg_rd = mtimecmp[31:0];
            TMR_CMP_HI:   reg_rd = mtimecmp[63:32];
            TMR_CTRL:     reg_rd = {{(24-PRESC_W){1'b0}}, presc,
                                    6'b0, irq_en, en};
            TMR_STATUS:   reg_rd = {30'b0, ovf, match};
`ifdef RV32_TIMER_MSIP_EN
            TMR_MSIP:     reg_rd = {31'b0, msip};
`endif
            default:      reg_rd = '0;
        endcase
    end

endmodule
